// File: rtl/ascii_num_stream_sep.sv
// ascii_num_stream_sep
// Streaming parser for ASCII decimal number lists. One payload byte is
// consumed per cycle. Tokens are separated by space, ',', tab, CR or LF.
// Each token is converted to a saturating DATA_WIDTH-bit integer (signed or
// unsigned) and written to an internal number RAM. The RAM is read through a
// registered port.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_data/in_valid/in_last/in_ready   byte stream input with handshake
//   rd_addr/rd_data   RAM read port, data valid one cycle after address
//   busy              packet in progress
//   done              one-cycle pulse after the last byte of a packet
//   invalid           sticky: illegal character or malformed token
//   overflow          sticky: at least one token saturated
//   full              sticky: at least one token dropped, RAM already full
//   num_count         numbers written in the current/last packet
module ascii_num_stream_sep #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1,
    parameter bit SIGNED     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  invalid,
    output logic                  overflow,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  num_count
);

    // Wide enough for mag*10+9 with mag up to 2^DATA_WIDTH.
    localparam int MW = DATA_WIDTH + 5;
    localparam logic [MW-1:0] ONE     = MW'(1);
    localparam logic [MW-1:0] LIM_POS = SIGNED ? ((ONE << (DATA_WIDTH - 1)) - ONE)
                                               : ((ONE << DATA_WIDTH) - ONE);
    localparam logic [MW-1:0] LIM_NEG = SIGNED ? (ONE << (DATA_WIDTH - 1)) : LIM_POS;
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PARSE, S_SKIP, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH:0]   mag_q, mag_d;
    logic                  neg_q, neg_d;
    logic                  tok_q, tok_d;      // token started (digit or '-')
    logic                  dig_q, dig_d;      // token holds at least one digit
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  inv_q, inv_d;
    logic                  ovf_q, ovf_d;
    logic                  full_q, full_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_val;

    logic                  is_digit, is_minus, is_sep;
    logic                  start, term, bad, sat, room;
    logic [DATA_WIDTH:0]   b_mag, t_mag, dmag;
    logic                  b_neg, b_tok, b_dig, t_neg;
    logic [CNT_WIDTH-1:0]  b_cnt;
    logic [MW-1:0]         mag_calc, lim;

    assign in_ready = (state_q != S_DONE);

    always_comb begin
        is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_minus = (in_data == 8'h2D);
        is_sep   = (in_data == 8'h20) || (in_data == 8'h2C) || (in_data == 8'h09) ||
                   (in_data == 8'h0D) || (in_data == 8'h0A);

        // The first byte of a packet sees a fresh token and cleared status.
        start = (state_q == S_IDLE);
        b_mag = start ? '0 : mag_q;
        b_neg = start ? 1'b0 : neg_q;
        b_tok = start ? 1'b0 : tok_q;
        b_dig = start ? 1'b0 : dig_q;
        b_cnt = start ? '0 : cnt_q;

        mag_calc = MW'(b_mag) * MW'(10) + MW'(in_data[3:0]);
        lim      = b_neg ? LIM_NEG : LIM_POS;
        sat      = (mag_calc > lim);
        dmag     = sat ? lim[DATA_WIDTH:0] : mag_calc[DATA_WIDTH:0];
        room     = (b_cnt < DEPTH_CNT);

        state_d = state_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        tok_d   = tok_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        full_d  = full_q;
        term    = 1'b0;
        bad     = 1'b0;
        t_mag   = b_mag;
        t_neg   = b_neg;
        wr_en   = 1'b0;
        wr_addr = b_cnt[ADDR_WIDTH-1:0];
        wr_val  = '0;

        if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (in_valid && state_q == S_SKIP) begin
            if (in_last) begin
                state_d = S_DONE;
            end
        end else if (in_valid) begin
            cnt_d  = b_cnt;
            inv_d  = start ? 1'b0 : inv_q;
            ovf_d  = start ? 1'b0 : ovf_q;
            full_d = start ? 1'b0 : full_q;
            tok_d  = b_tok;
            dig_d  = b_dig;

            if (is_digit) begin
                t_mag = dmag;
                tok_d = 1'b1;
                dig_d = 1'b1;
                if (sat) begin
                    ovf_d = 1'b1;
                end
                term = in_last;
            end else if (is_minus && SIGNED && !b_tok) begin
                t_neg = 1'b1;
                tok_d = 1'b1;
                bad   = in_last;      // a packet ending on a bare '-'
            end else if (is_sep) begin
                term = b_tok && b_dig;
                bad  = b_tok && !b_dig;
            end else begin
                bad = 1'b1;
            end

            wr_val = t_neg ? -t_mag[DATA_WIDTH-1:0] : t_mag[DATA_WIDTH-1:0];
            // Gated by rst so a byte presented during reset cannot touch the RAM.
            wr_en  = term && room && !rst;
            if (term && room) begin
                cnt_d = b_cnt + 1'b1;
            end
            if (term && !room) begin
                full_d = 1'b1;
            end
            if (bad) begin
                inv_d = 1'b1;
            end

            if (term || bad) begin
                mag_d = '0;
                neg_d = 1'b0;
                tok_d = 1'b0;
                dig_d = 1'b0;
            end else begin
                mag_d = t_mag;
                neg_d = t_neg;
            end

            state_d = in_last ? S_DONE : (bad ? S_SKIP : S_PARSE);
        end

        busy_d = (state_d == S_PARSE) || (state_d == S_SKIP);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            tok_q   <= 1'b0;
            dig_q   <= 1'b0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            tok_q   <= tok_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
            full_q  <= full_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Number RAM: contents survive reset and new packets.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_val;
        end
    end

    // Registered read; a same-address write returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign invalid   = inv_q;
    assign overflow  = ovf_q;
    assign full      = full_q;
    assign num_count = cnt_q;

endmodule

// File: tb/tb_ascii_num_stream_sep.sv
// Bench for ascii_num_stream_sep. Three instances share one input stream:
//   0: 32-bit signed, DEPTH 2048   1: 32-bit signed, DEPTH 4
//   2: 8-bit unsigned, DEPTH 16
// A table of hand-derived vectors is followed by a reset sequence and by
// random packets compared against a token-level reference model.
module tb_ascii_num_stream_sep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [10:0] rd_addr = '0;

    logic [2:0]  rdy_w, busy_w, done_w, inv_w, ovf_w, full_w;
    logic [31:0] rd0, rd1;
    logic [7:0]  rd2;
    logic [11:0] cnt0;
    logic [2:0]  cnt1;
    logic [4:0]  cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascii_num_stream_sep u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_w[0]), .rd_addr(rd_addr), .rd_data(rd0), .busy(busy_w[0]),
        .done(done_w[0]), .invalid(inv_w[0]), .overflow(ovf_w[0]), .full(full_w[0]),
        .num_count(cnt0)
    );

    ascii_num_stream_sep #(.DATA_WIDTH(32), .DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_w[1]), .rd_addr(rd_addr[1:0]), .rd_data(rd1), .busy(busy_w[1]),
        .done(done_w[1]), .invalid(inv_w[1]), .overflow(ovf_w[1]), .full(full_w[1]),
        .num_count(cnt1)
    );

    ascii_num_stream_sep #(.DATA_WIDTH(8), .DEPTH(16), .SIGNED(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_w[2]), .rd_addr(rd_addr[3:0]), .rd_data(rd2), .busy(busy_w[2]),
        .done(done_w[2]), .invalid(inv_w[2]), .overflow(ovf_w[2]), .full(full_w[2]),
        .num_count(cnt2)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned get_cnt(input int sel);
        case (sel)
            0:       return 64'(cnt0);
            1:       return 64'(cnt1);
            default: return 64'(cnt2);
        endcase
    endfunction

    function automatic longint unsigned get_rd(input int sel);
        case (sel)
            0:       return 64'(rd0);
            1:       return 64'(rd1);
            default: return 64'(rd2);
        endcase
    endfunction

    function automatic bit is_sep(input byte c);
        return c == 8'h20 || c == 8'h2C || c == 8'h09 || c == 8'h0D || c == 8'h0A;
    endfunction

    // Drives one packet; inputs change 1 time unit after the rising edge.
    task automatic send_pkt(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(posedge clk); #1;
                if (i > 0) chk("busy_in_gap", 64'(busy_w), 64'h7);
            end
            in_data  = s[i];
            in_valid = 1'b1;
            in_last  = (i == s.len() - 1);
            chk("in_ready", 64'(rdy_w), 64'h7);
            if (i > 0) chk("busy", 64'(busy_w), 64'h7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("done_pulse", 64'(done_w), 64'h7);
        chk("ready_in_done", 64'(rdy_w), 64'h0);
        chk("busy_in_done", 64'(busy_w), 64'h0);
        @(posedge clk); #1;
        chk("done_low", 64'(done_w), 64'h0);
    endtask

    // ---------------- reference model ----------------
    int              m_cnt;
    bit              m_inv, m_ovf, m_full;
    longint unsigned m_vals [32];

    // Splits the packet into runs of non-separator characters and evaluates
    // each with saturating decimal arithmetic; the first bad token ends parsing.
    task automatic model(input string s, input int w, input int depth, input bit sgn);
        longint unsigned lim_p, lim_n, mag, mask;
        bit neg, dig, bad, stop;
        int i, j;
        byte c;
        m_cnt = 0; m_inv = 0; m_ovf = 0; m_full = 0;
        mask  = (64'd1 << w) - 1;
        lim_p = sgn ? (64'd1 << (w - 1)) - 1 : mask;
        lim_n = sgn ? (64'd1 << (w - 1)) : lim_p;
        i = 0; stop = 0;
        while (i < s.len() && !stop) begin
            if (is_sep(s[i])) begin
                i++;
            end else begin
                mag = 0; neg = 0; dig = 0; bad = 0; j = i;
                while (j < s.len() && !is_sep(s[j]) && !bad) begin
                    c = s[j];
                    if (c >= 8'h30 && c <= 8'h39) begin
                        dig = 1;
                        mag = mag * 10 + longint'(c - 8'h30);
                        if (mag > (neg ? lim_n : lim_p)) begin
                            mag   = neg ? lim_n : lim_p;
                            m_ovf = 1;
                        end
                    end else if (c == 8'h2D && j == i && sgn) begin
                        neg = 1;
                    end else begin
                        bad = 1;
                    end
                    j++;
                end
                if (bad || !dig) begin
                    m_inv = 1;
                    stop  = 1;
                end else if (m_cnt < depth) begin
                    m_vals[m_cnt] = neg ? ((~mag + 1) & mask) : mag;
                    m_cnt++;
                end else begin
                    m_full = 1;
                end
                i = j;
            end
        end
    endtask

    task automatic check_dut(input int sel, input int ecnt, input bit einv, input bit eovf,
                             input bit efull);
        chk($sformatf("dut%0d count", sel), get_cnt(sel), 64'(ecnt));
        chk($sformatf("dut%0d invalid", sel), 64'(inv_w[sel]), 64'(einv));
        chk($sformatf("dut%0d overflow", sel), 64'(ovf_w[sel]), 64'(eovf));
        chk($sformatf("dut%0d full", sel), 64'(full_w[sel]), 64'(efull));
        for (int k = 0; k < ecnt && k < 32; k++) begin
            rd_addr = 11'(k);
            @(posedge clk); #1;
            chk($sformatf("dut%0d ram[%0d]", sel, k), get_rd(sel), m_vals[k]);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string           pkt;
        int              sel;
        int              gap;
        int              cnt;
        bit              inv;
        bit              ovf;
        bit              full;
        longint unsigned v0, v1, v2, v3;
    } vec_t;

    function automatic vec_t mk(input string p, input int sel, input int gap, input int cnt,
                                input bit inv, input bit ovf, input bit full,
                                input longint unsigned v0 = 0, input longint unsigned v1 = 0,
                                input longint unsigned v2 = 0, input longint unsigned v3 = 0);
        vec_t v;
        v.pkt = p; v.sel = sel; v.gap = gap; v.cnt = cnt;
        v.inv = inv; v.ovf = ovf; v.full = full;
        v.v0 = v0; v.v1 = v1; v.v2 = v2; v.v3 = v3;
        return v;
    endfunction

    vec_t vecs [$];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string   s, one;
        int      n, dpct, r;
        byte     ch;
        int      widths [3] = '{32, 32, 8};
        int      depths [3] = '{2048, 4, 16};
        bit      sgns   [3] = '{1'b1, 1'b1, 1'b0};

        vecs.push_back(mk("12 -34,5\n", 0, 0, 3, 0, 0, 0, 64'hC, 64'hFFFFFFDE, 64'h5));
        vecs.push_back(mk("2147483648 -2147483649 -2147483648", 0, 0, 3, 0, 1, 0,
                          64'h7FFFFFFF, 64'h80000000, 64'h80000000));
        vecs.push_back(mk("7 a 9", 0, 0, 1, 1, 0, 0, 64'h7));
        vecs.push_back(mk("3-4", 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("-", 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("5 -\n", 0, 0, 1, 1, 0, 0, 64'h5));
        vecs.push_back(mk("1 2 3 4 5 6", 1, 0, 4, 0, 0, 1, 64'h1, 64'h2, 64'h3, 64'h4));
        vecs.push_back(mk("255,,256 -1", 2, 0, 2, 1, 1, 0, 64'hFF, 64'hFF));
        vecs.push_back(mk("99 100", 0, 0, 2, 0, 0, 0, 64'h63, 64'h64));
        vecs.push_back(mk("99 100", 0, 60, 2, 0, 0, 0, 64'h63, 64'h64));
        vecs.push_back(mk("-0 007\n", 0, 0, 2, 0, 0, 0, 64'h0, 64'h7));
        vecs.push_back(mk("\n", 0, 0, 0, 0, 0, 0));

        // Reset values while rst is held.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst count", get_cnt(0), 0);
        chk("rst busy", 64'(busy_w), 0);
        chk("rst done", 64'(done_w), 0);
        chk("rst flags", 64'({inv_w, ovf_w, full_w}), 0);
        chk("rst rd_data", get_rd(0), 0);
        chk("rst in_ready", 64'(rdy_w), 64'h7);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[t]) begin
            send_pkt(vecs[t].pkt, vecs[t].gap);
            m_vals[0] = vecs[t].v0; m_vals[1] = vecs[t].v1;
            m_vals[2] = vecs[t].v2; m_vals[3] = vecs[t].v3;
            $display("vec %0d dut%0d count=%0d inv=%0b ovf=%0b full=%0b", t, vecs[t].sel,
                     get_cnt(vecs[t].sel), inv_w[vecs[t].sel], ovf_w[vecs[t].sel],
                     full_w[vecs[t].sel]);
            check_dut(vecs[t].sel, vecs[t].cnt, vecs[t].inv, vecs[t].ovf, vecs[t].full);
        end

        // Leave stale flags set, then abort a packet with reset.
        send_pkt("99999999999 x", 0);
        chk("stale invalid", 64'(inv_w[0]), 1);
        chk("stale overflow", 64'(ovf_w[0]), 1);
        s = "12 3";
        for (int i = 0; i < s.len(); i++) begin
            in_data = s[i]; in_valid = 1'b1; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort count", get_cnt(0), 0);
        chk("abort busy", 64'(busy_w), 0);
        chk("abort flags", 64'({inv_w, ovf_w, full_w}), 0);
        chk("abort rd_data", get_rd(0), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort no done", 64'(done_w), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort no done after", 64'(done_w), 0);
        send_pkt("8", 0);
        m_vals[0] = 64'h8;
        $display("reset-recovery count=%0d inv=%0b ovf=%0b", cnt0, inv_w[0], ovf_w[0]);
        check_dut(0, 1, 0, 0, 0);

        // Random packets against the model, all three configurations.
        for (int p = 0; p < 40; p++) begin
            n    = $urandom_range(24, 1);
            dpct = ($urandom_range(1) == 1) ? 85 : 55;
            s    = "";
            one  = " ";
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(99);
                if (r < dpct)                 ch = byte'(8'h30 + $urandom_range(9));
                else if (r < dpct + (95 - dpct) * 2 / 3) begin
                    case ($urandom_range(2))
                        0:       ch = 8'h20;
                        1:       ch = 8'h2C;
                        default: ch = 8'h0A;
                    endcase
                end else if (r < 97)          ch = 8'h2D;
                else                          ch = 8'h78;
                one.putc(0, ch);
                s = {s, one};
            end
            send_pkt(s, 25);
            $display("rnd %0d len=%0d counts=%0d/%0d/%0d inv=%b ovf=%b full=%b", p, n,
                     cnt0, cnt1, cnt2, inv_w, ovf_w, full_w);
            for (int sel = 0; sel < 3; sel++) begin
                model(s, widths[sel], depths[sel], sgns[sel]);
                check_dut(sel, m_cnt, m_inv, m_ovf, m_full);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_num_stream_sep.md
# ascii_num_stream_sep

Streaming, parametrised successor to the buffered ASCII number separator. It sits between the UART packet deframer and the matrix loader. It consumes the payload byte stream one byte per cycle with no payload buffer, and parses decimal tokens as signed or unsigned integers of configurable width with saturation. Results go into an internal number RAM that downstream modules read through a registered read port.

## Interface
- DATA_WIDTH, 32, width of stored integers (2..64)
- DEPTH, 2048, number RAM entries
- ADDR_WIDTH, $clog2(DEPTH), RAM address width
- CNT_WIDTH, ADDR_WIDTH+1, count width (must represent DEPTH)
- SIGNED, 1, 1: '-' prefix allowed, two's-complement range; 0: '-' is an invalid character, unsigned range
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  payload byte
- in_valid  input  1  byte valid
- in_last  input  1  final byte of packet, qualified by in_valid
- in_ready  output  1  byte accepted when in_valid && in_ready
- rd_addr  input  ADDR_WIDTH  RAM read address
- rd_data  output  DATA_WIDTH  RAM data, registered
- busy  output  1  packet in progress (first byte accepted, done not yet pulsed)
- done  output  1  one-cycle pulse at end of packet
- invalid  output  1  sticky: illegal character or malformed token in packet
- overflow  output  1  sticky: at least one token saturated
- full  output  1  sticky: at least one token dropped because RAM held DEPTH numbers
- num_count  output  CNT_WIDTH  numbers written in current/last packet

## Operation
- States: IDLE, PARSE, SKIP, DONE.
  - IDLE→PARSE on first accepted byte. That byte clears num_count, invalid, overflow, full and is processed normally.
  - PARSE→SKIP on an invalid condition.
  - PARSE/SKIP→DONE on an accepted byte with in_last=1, including the IDLE first byte if it is last.
  - DONE→IDLE unconditionally after 1 cycle.
- Character classes:
  - Digits '0'-'9'.
  - '-' is legal only as the first character of a token, and only when SIGNED=1.
  - Separators are space, ',', tab, CR, LF.
  - Anything else is invalid.
- Tokens:
  - A token ends on a separator or on the last byte. A digit carried on the last byte is included in the token.
  - Consecutive separators produce no entry.
  - A token of only '-' is invalid. So is '-' appearing mid-token.
- Invalid condition: set invalid, discard the current token, enter SKIP. In SKIP, bytes are accepted and ignored until in_last. Numbers already written are kept, and num_count reflects them.
- Arithmetic:
  - The magnitude register is DATA_WIDTH+1 bits.
  - Per digit: mag_next = mag*10+d, computed at DATA_WIDTH+5 bits.
  - Limit is 2^(W-1)-1 for positive and 2^(W-1) for negative when SIGNED=1, and 2^W-1 when SIGNED=0.
  - If mag_next exceeds the limit, mag saturates at the limit and overflow is set. Later digits of that token keep it saturated.
  - Stored value = neg ? -mag : mag, truncated to DATA_WIDTH.
  - Leading zeros are allowed. "-0" stores 0.
- Write:
  - When a token terminates with num_count < DEPTH, store it at address num_count and increment num_count on the same edge.
  - When num_count == DEPTH, drop the value and set full (not invalid).
- RAM is not cleared by reset or by a new packet.
- Read-during-write to the same address returns the old data.

## Timing
- in_ready = 1 in IDLE, PARSE and SKIP; 0 in DONE. Throughput is 1 byte/cycle, and in_valid gaps are allowed anywhere.
- The RAM write and num_count update happen on the edge that accepts the terminating byte, so there are no extra cycles.
- done is high in the cycle after the last-byte handshake. At that point num_count and the status flags are final, and RAM contents are readable.
- rd_data is valid 1 cycle after rd_addr.
- Status outputs hold until the next packet's first byte is accepted.
- Reset values:
  - State IDLE.
  - in_ready=1 (it is a function of state).
  - busy=0, done=0, invalid=0, overflow=0, full=0, num_count=0, rd_data=0.
- Reset mid-packet aborts the packet with no done pulse. The next accepted byte starts a new packet.

## Test plan
- "12 -34,5\n", last on '\n' → num_count=3; RAM[0..2]=0x0000000C, 0xFFFFFFDE, 0x00000005; done exactly 1 cycle after last; invalid=overflow=full=0.
- "2147483648 -2147483649 -2147483648", last on final '8' → 0x7FFFFFFF, 0x80000000, 0x80000000; overflow=1; num_count=3.
- "7 a 9" → invalid=1, num_count=1, RAM[0]=7. Bytes after 'a' are accepted (in_ready=1) and ignored; done follows last. "3-4" and lone "-" also → invalid.
- DEPTH=4: "1 2 3 4 5 6" → num_count=4, RAM 1..4, full=1, invalid=0.
- SIGNED=0, DATA_WIDTH=8: "255,,256 -1" → RAM 0xFF, 0xFF; overflow=1; invalid=1 on '-'; num_count=2.
- Random in_valid gaps on "99 100" → same result as gapless. Assert rst mid-packet → all outputs 0, no done. Next packet "8" → num_count=1, RAM[0]=8, and the stale flags are cleared.
